// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_pkg
// Brief    : Shared types and helpers for the MEM-stage store buffer.
// Revision : 1.0
// ============================================================================
package sb_pkg;

  typedef enum logic [1:0] {
    SB_BYTE = 2'b00,
    SB_HALF = 2'b01,
    SB_WORD = 2'b10,
    SB_BAD  = 2'b11
  } sb_size_t;

  typedef struct packed {
    logic [31:0] address;
    sb_size_t    size;
    logic [31:0] data;
  } sb_entry_t;

  // Access length in bytes; the illegal code is treated as a full word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   size_to_len = 3'd1;
      2'b01:   size_to_len = 3'd2;
      default: size_to_len = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_overlap.sv
`default_nettype none
// ============================================================================
// Module   : sb_overlap
// Brief    : Byte-range intersect of one buffered store against the load.
// Revision : 1.0
// ============================================================================
module sb_overlap
  import sb_pkg::*;
(
  input  logic        entry_valid,
  input  logic [31:0] entry_address,
  input  logic [1:0]  entry_size,
  input  logic [31:0] ld_address,
  input  logic [2:0]  ld_len,
  output logic        hit
);

  logic [2:0]  w_st_len;
  logic [31:0] w_ld_minus_st;
  logic [31:0] w_st_minus_ld;

  // Modular distances keep the test correct when a range wraps past 2^32.
  assign w_st_len      = size_to_len(entry_size);
  assign w_ld_minus_st = ld_address - entry_address;
  assign w_st_minus_ld = entry_address - ld_address;

  assign hit = entry_valid &&
               ((w_ld_minus_st < {29'd0, w_st_len}) ||
                (w_st_minus_ld < {29'd0, ld_len}));

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : In-order posted-write buffer ahead of Datamem with load hazard stall.
// Revision : 1.0
// ============================================================================
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_address,
  input  logic [1:0]                 st_size,
  input  logic [31:0]                st_data,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_address,
  input  logic [2:0]                 ld_flags,
  output logic                       ld_stall,
  output logic [31:0]                mem_address,
  output logic [2:0]                 mem_flags_read,
  output logic [1:0]                 mem_flags_write,
  output logic [31:0]                mem_wdata,
  output logic                       mem_we,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_size
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  sb_entry_t      r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           r_err_size;

  logic             w_push;
  logic             w_bad;
  logic             w_drain;
  logic [2:0]       w_ld_len;
  logic [DEPTH-1:0] w_hits;
  sb_entry_t        w_head;

  assign st_ready = (r_count != c_full);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign err_size = r_err_size;

  assign w_push   = st_valid && st_ready && (st_size != 2'b11);
  assign w_bad    = st_valid && st_ready && (st_size == 2'b11);
  assign w_ld_len = size_to_len(ld_flags[1:0]);
  assign w_head   = r_mem[r_head];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_overlap
      sb_overlap u_overlap (
        .entry_valid   (r_valid[gi]),
        .entry_address (r_mem[gi].address),
        .entry_size    (r_mem[gi].size),
        .ld_address    (ld_address),
        .ld_len        (w_ld_len),
        .hit           (w_hits[gi])
      );
    end
  endgenerate

  assign ld_stall = ld_valid && (|w_hits);
  assign w_drain  = !empty && (!ld_valid || ld_stall);

  always_comb begin
    mem_address     = ld_address;
    mem_flags_read  = ld_flags;
    mem_flags_write = 2'b00;
    mem_wdata       = 32'd0;
    mem_we          = 1'b0;
    if (w_drain) begin
      mem_address     = w_head.address;
      mem_flags_write = w_head.size;
      mem_wdata       = w_head.data;
      mem_we          = 1'b1;
    end
  end

  // Payload needs no reset: occupancy is tracked by r_valid and r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_tail] <= '{address: st_address, size: sb_size_t'(st_size), data: st_data};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_err_size <= 1'b0;
    end else begin
      r_err_size <= w_bad;
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push && !w_drain) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_drain) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire
